// File: rtl/ring_router_node.sv
// rtl/ring_router_node.sv - one node of the bidirectional two-VC ring NoC
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   polarity              current VC phase (write phase = polarity, read phase = ~polarity)
//   cwsi/cwri/cwdi        cw link input from upstream (send, ready, data)
//   ccwsi/ccwri/ccwdi     ccw link input from upstream
//   pesi/peri/pedi        PE injection
//   cwso/cwro/cwdo        cw link output to downstream
//   ccwso/ccwro/ccwdo     ccw link output to downstream
//   peso/pero/pedo        PE ejection
// Packet map: [63] vc, [62] dir, [61:56] res, [55:48] hop, [47:32] src, [31:0] payload
module ring_router_node #(
    parameter int PAC_SIZE = 64
) (
    input  logic                clk,
    input  logic                reset,
    output logic                polarity,
    input  logic                cwsi,
    output logic                cwri,
    input  logic [PAC_SIZE-1:0] cwdi,
    input  logic                ccwsi,
    output logic                ccwri,
    input  logic [PAC_SIZE-1:0] ccwdi,
    input  logic                pesi,
    output logic                peri,
    input  logic [PAC_SIZE-1:0] pedi,
    output logic                cwso,
    input  logic                cwro,
    output logic [PAC_SIZE-1:0] cwdo,
    output logic                ccwso,
    input  logic                ccwro,
    output logic [PAC_SIZE-1:0] ccwdo,
    output logic                peso,
    input  logic                pero,
    output logic [PAC_SIZE-1:0] pedo
);

    logic                r_pol;
    logic                r_rr;
    logic [1:0]          r_cw_v;
    logic [1:0]          r_ccw_v;
    logic [1:0]          r_pe_v;
    logic [PAC_SIZE-1:0] r_cw_d  [0:1];
    logic [PAC_SIZE-1:0] r_ccw_d [0:1];
    logic [PAC_SIZE-1:0] r_pe_d  [0:1];

    // Read side always uses the VC opposite to the one being written.
    logic                w_q;
    logic [PAC_SIZE-1:0] w_cw_pkt, w_ccw_pkt, w_pe_pkt;
    logic                w_cw_vld, w_ccw_vld, w_pe_vld;
    logic                w_cw_ej, w_cw_fw, w_ccw_ej, w_ccw_fw;
    logic                w_cwo_cw, w_cwo_pe, w_ccwo_ccw, w_ccwo_pe;
    logic                w_peo_cw, w_peo_ccw, w_tie;
    logic                w_cw_clr, w_ccw_clr, w_pe_clr;
    logic [PAC_SIZE-1:0] w_cw_fwd, w_ccw_fwd, w_pe_out;

    assign w_q       = ~r_pol;
    assign w_cw_pkt  = r_cw_d[w_q];
    assign w_ccw_pkt = r_ccw_d[w_q];
    assign w_pe_pkt  = r_pe_d[w_q];
    assign w_cw_vld  = r_cw_v[w_q];
    assign w_ccw_vld = r_ccw_v[w_q];
    assign w_pe_vld  = r_pe_v[w_q];

    // hop[7:1] == 0 means this is the last hop: eject locally.
    assign w_cw_ej   = w_cw_vld  && (w_cw_pkt[55:49]  == 7'd0);
    assign w_cw_fw   = w_cw_vld  && !w_cw_ej;
    assign w_ccw_ej  = w_ccw_vld && (w_ccw_pkt[55:49] == 7'd0);
    assign w_ccw_fw  = w_ccw_vld && !w_ccw_ej;

    // Grants are suppressed during reset so a discarded packet never pulses out.
    assign w_cwo_cw   = reset && w_cw_fw;
    assign w_cwo_pe   = reset && !w_cw_fw && w_pe_vld && !w_pe_pkt[62];
    assign w_ccwo_ccw = reset && w_ccw_fw;
    assign w_ccwo_pe  = reset && !w_ccw_fw && w_pe_vld && w_pe_pkt[62];
    assign w_tie      = w_cw_ej && w_ccw_ej;
    assign w_peo_cw   = reset && w_cw_ej  && (!w_ccw_ej || !r_rr);
    assign w_peo_ccw  = reset && w_ccw_ej && (!w_cw_ej  ||  r_rr);

    assign cwso  = (w_cwo_cw || w_cwo_pe) && cwro;
    assign ccwso = (w_ccwo_ccw || w_ccwo_pe) && ccwro;
    assign peso  = (w_peo_cw || w_peo_ccw) && pero;

    // Outgoing packets carry the current phase as their VC; forwards halve hop.
    assign w_cw_fwd  = {r_pol, w_cw_pkt[62:56],  1'b0, w_cw_pkt[55:49],  w_cw_pkt[47:0]};
    assign w_ccw_fwd = {r_pol, w_ccw_pkt[62:56], 1'b0, w_ccw_pkt[55:49], w_ccw_pkt[47:0]};
    assign w_pe_out  = {r_pol, w_pe_pkt[62:0]};

    assign cwdo  = cwso  ? (w_cwo_cw   ? w_cw_fwd  : w_pe_out) : '0;
    assign ccwdo = ccwso ? (w_ccwo_ccw ? w_ccw_fwd : w_pe_out) : '0;
    assign pedo  = peso  ? (w_peo_cw ? {r_pol, w_cw_pkt[62:0]} : {r_pol, w_ccw_pkt[62:0]}) : '0;

    assign w_cw_clr  = (w_cwo_cw   && cwro)  || (w_peo_cw  && pero);
    assign w_ccw_clr = (w_ccwo_ccw && ccwro) || (w_peo_ccw && pero);
    assign w_pe_clr  = (w_cwo_pe && cwro) || (w_ccwo_pe && ccwro);

    assign polarity = r_pol;
    assign cwri     = reset && !r_cw_v[r_pol];
    assign ccwri    = reset && !r_ccw_v[r_pol];
    assign peri     = reset && !r_pe_v[r_pol];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pol      <= 1'b0;
            r_rr       <= 1'b0;
            r_cw_v     <= 2'b00;
            r_ccw_v    <= 2'b00;
            r_pe_v     <= 2'b00;
            r_cw_d[0]  <= '0;
            r_cw_d[1]  <= '0;
            r_ccw_d[0] <= '0;
            r_ccw_d[1] <= '0;
            r_pe_d[0]  <= '0;
            r_pe_d[1]  <= '0;
        end else begin
            r_pol <= ~r_pol;
            // Pointer moves to the loser only on a genuine tie.
            if (w_tie) begin
                r_rr <= ~r_rr;
            end
            // Write index (r_pol) and clear index (w_q) always differ.
            if (cwsi && cwri) begin
                r_cw_v[r_pol] <= 1'b1;
                r_cw_d[r_pol] <= cwdi;
            end
            if (ccwsi && ccwri) begin
                r_ccw_v[r_pol] <= 1'b1;
                r_ccw_d[r_pol] <= ccwdi;
            end
            if (pesi && peri) begin
                r_pe_v[r_pol] <= 1'b1;
                r_pe_d[r_pol] <= pedi;
            end
            if (w_cw_clr) begin
                r_cw_v[w_q] <= 1'b0;
            end
            if (w_ccw_clr) begin
                r_ccw_v[w_q] <= 1'b0;
            end
            if (w_pe_clr) begin
                r_pe_v[w_q] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ring_router_node.sv
// tb/tb_ring_router_node.sv - self-checking bench for ring_router_node
module tb_ring_router_node;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        polarity;
    logic        cwsi = 1'b0, ccwsi = 1'b0, pesi = 1'b0;
    logic        cwri, ccwri, peri;
    logic [63:0] cwdi = '0, ccwdi = '0, pedi = '0;
    logic        cwso, ccwso, peso;
    logic        cwro = 1'b1, ccwro = 1'b1, pero = 1'b1;
    logic [63:0] cwdo, ccwdo, pedo;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ring_router_node #(.PAC_SIZE(64)) dut (
        .clk(clk), .reset(reset), .polarity(polarity),
        .cwsi(cwsi), .cwri(cwri), .cwdi(cwdi),
        .ccwsi(ccwsi), .ccwri(ccwri), .ccwdi(ccwdi),
        .pesi(pesi), .peri(peri), .pedi(pedi),
        .cwso(cwso), .cwro(cwro), .cwdo(cwdo),
        .ccwso(ccwso), .ccwro(ccwro), .ccwdo(ccwdo),
        .peso(peso), .pero(pero), .pedo(pedo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic vc, input logic dir, input logic [7:0] hop,
                                       input logic [15:0] src, input logic [31:0] pay);
        return {vc, dir, 6'b0, hop, src, pay};
    endfunction

    // ---------------- behavioural model ----------------
    // Outputs: 0 = cw-out, 1 = ccw-out, 2 = pe-out. Sources: 0 cw-in, 1 ccw-in, 2 pe-in.
    logic        m_pol;
    logic        m_rr;
    logic        m_v [3][2];
    logic [63:0] m_d [3][2];

    function automatic int dest_of(input int src, input logic [63:0] pkt);
        if (src == 2) return pkt[62] ? 1 : 0;
        if (pkt[55:48] < 8'd2) return 2;
        return src;
    endfunction

    function automatic logic [63:0] out_of(input int src, input logic [63:0] pkt, input logic pol);
        logic [63:0] r;
        r = pkt;
        if (src != 2 && pkt[55:48] >= 8'd2) r[55:48] = pkt[55:48] / 2;
        r[63] = pol;
        return r;
    endfunction

    initial begin
        m_pol = 1'b0;
        m_rr  = 1'b0;
        for (int s = 0; s < 3; s++)
            for (int v = 0; v < 2; v++) begin
                m_v[s][v] = 1'b0;
                m_d[s][v] = '0;
            end
        @(posedge clk);
        forever begin
            int          q;
            int          win [3];
            logic        req [3][3];
            logic        ro  [3];
            logic        si  [3];
            logic [63:0] di  [3];
            logic        e_so [3];
            logic [63:0] e_do [3];
            logic        e_ri [3];
            logic        a_so [3];
            logic [63:0] a_do [3];
            logic        a_ri [3];
            @(negedge clk);
            q  = m_pol ? 0 : 1;
            ro = '{cwro, ccwro, pero};
            si = '{cwsi, ccwsi, pesi};
            di = '{cwdi, ccwdi, pedi};
            a_so = '{cwso, ccwso, peso};
            a_do = '{cwdo, ccwdo, pedo};
            a_ri = '{cwri, ccwri, peri};
            for (int o = 0; o < 3; o++)
                for (int s = 0; s < 3; s++)
                    req[o][s] = m_v[s][q] && (dest_of(s, m_d[s][q]) == o);
            win[0] = req[0][0] ? 0 : (req[0][2] ? 2 : -1);
            win[1] = req[1][1] ? 1 : (req[1][2] ? 2 : -1);
            if (req[2][0] && req[2][1]) win[2] = m_rr ? 1 : 0;
            else                        win[2] = req[2][0] ? 0 : (req[2][1] ? 1 : -1);
            for (int o = 0; o < 3; o++) begin
                e_so[o] = reset && (win[o] >= 0) && ro[o];
                e_do[o] = e_so[o] ? out_of(win[o], m_d[win[o]][q], m_pol) : 64'd0;
                e_ri[o] = reset && !m_v[o][m_pol];
                check($sformatf("model_so%0d", o), a_so[o], e_so[o]);
                check($sformatf("model_do%0d", o), a_do[o], e_do[o]);
                check($sformatf("model_ri%0d", o), a_ri[o], e_ri[o]);
            end
            check("model_pol", polarity, m_pol);
            if (!reset) begin
                m_pol = 1'b0;
                m_rr  = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    m_v[s][0] = 1'b0;
                    m_v[s][1] = 1'b0;
                end
            end else begin
                for (int o = 0; o < 3; o++)
                    if (e_so[o]) m_v[win[o]][q] = 1'b0;
                if (req[2][0] && req[2][1]) m_rr = ~m_rr;
                for (int s = 0; s < 3; s++)
                    if (si[s] && e_ri[s]) begin
                        m_v[s][m_pol] = 1'b1;
                        m_d[s][m_pol] = di[s];
                    end
                m_pol = ~m_pol;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pol(input logic p);
        for (int i = 0; i < 3 && polarity !== p; i++) tick();
        check("wait_pol", polarity, p);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        // Reset
        repeat (3) tick();
        check("rst_cwso", cwso, 0);
        check("rst_peso", peso, 0);
        check("rst_cwri", cwri, 0);
        check("rst_peri", peri, 0);
        check("rst_pol", polarity, 0);
        reset = 1'b1;
        #1;
        check("rel_cwri", cwri, 1);
        check("rel_pol0", polarity, 0);
        tick();
        check("rel_pol1", polarity, 1);
        tick();
        check("rel_pol2", polarity, 0);

        // PE inject cw, hop 3, src 0, payload 2 during polarity 0
        wait_pol(0);
        pedi = mk(0, 0, 8'h03, 16'h0000, 32'h2); pesi = 1'b1;
        tick();
        pesi = 1'b0; pedi = '0;
        check("inj_cwso", cwso, 1);
        check("inj_cwdo", cwdo, mk(1, 0, 8'h03, 16'h0000, 32'h2));
        check("inj_ccwso", ccwso, 0);
        tick();

        // cw arrival that ejects, then one that forwards
        wait_pol(1);
        cwdi = mk(0, 0, 8'h01, 16'h0003, 32'hDEADBEEF); cwsi = 1'b1;
        tick();
        cwsi = 1'b0;
        check("ej_peso", peso, 1);
        check("ej_pedo", pedo, mk(0, 0, 8'h01, 16'h0003, 32'hDEADBEEF));
        check("ej_cwso", cwso, 0);
        tick();
        wait_pol(1);
        cwdi = mk(1, 0, 8'h03, 16'h0005, 32'h11); cwsi = 1'b1;
        tick();
        cwsi = 1'b0;
        check("fw_cwso", cwso, 1);
        check("fw_cwdo", cwdo, mk(0, 0, 8'h01, 16'h0005, 32'h11));
        tick();

        // cw-in forward beats pe-in for cw-out
        wait_pol(0);
        cwdi = mk(0, 0, 8'h04, 16'h0007, 32'hA); cwsi = 1'b1;
        pedi = mk(0, 0, 8'h02, 16'h0009, 32'hB); pesi = 1'b1;
        tick();
        cwsi = 1'b0; pesi = 1'b0;
        check("pri_first", cwdo, mk(1, 0, 8'h02, 16'h0007, 32'hA));
        tick();
        check("pri_gap", cwso, 0);
        tick();
        check("pri_second", cwdo, mk(1, 0, 8'h02, 16'h0009, 32'hB));
        tick();

        // Eject ties: cw first, then ccw; next tie goes to ccw
        wait_pol(0);
        cwdi  = mk(0, 0, 8'h01, 16'h0001, 32'hC1); cwsi  = 1'b1;
        ccwdi = mk(0, 1, 8'h00, 16'h0002, 32'hC2); ccwsi = 1'b1;
        tick();
        cwsi = 1'b0; ccwsi = 1'b0;
        check("tie1_a", pedo, mk(1, 0, 8'h01, 16'h0001, 32'hC1));
        tick();
        check("tie1_gap", peso, 0);
        tick();
        check("tie1_b", pedo, mk(1, 1, 8'h00, 16'h0002, 32'hC2));
        tick();
        wait_pol(0);
        cwdi  = mk(0, 0, 8'h01, 16'h0003, 32'hD1); cwsi  = 1'b1;
        ccwdi = mk(0, 1, 8'h01, 16'h0004, 32'hD2); ccwsi = 1'b1;
        tick();
        cwsi = 1'b0; ccwsi = 1'b0;
        check("tie2_a", pedo, mk(1, 1, 8'h01, 16'h0004, 32'hD2));
        tick();
        tick();
        check("tie2_b", pedo, mk(1, 0, 8'h01, 16'h0003, 32'hD1));
        tick();

        // Backpressure on pe-out
        wait_pol(0);
        pero = 1'b0;
        cwdi = mk(0, 0, 8'h01, 16'h000E, 32'hE0); cwsi = 1'b1;
        tick();
        cwsi = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cnt += int'(peso);
            tick();
        end
        check("bp_hold", cnt, 0);
        wait_pol(0);
        check("bp_cwri", cwri, 0);
        pero = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cnt += int'(peso);
            tick();
        end
        check("bp_release", cnt, 1);

        // Reset right after an injection discards it
        wait_pol(0);
        pedi = mk(0, 1, 8'h01, 16'h0000, 32'h77); pesi = 1'b1;
        tick();
        pesi = 1'b0;
        reset = 1'b0;
        #1;
        cnt = int'(cwso) + int'(ccwso) + int'(peso);
        tick();
        cnt += int'(cwso) + int'(ccwso) + int'(peso);
        check("rst2_pol", polarity, 0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cnt += int'(cwso) + int'(ccwso) + int'(peso);
            tick();
        end
        check("rst2_discard", cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
